// File: rtl/dce_err_pkg.sv
// Shared types and default widths for the DCE correctable-error logger.
package dce_err_pkg;

  localparam int unsigned DefWType = 4;
  localparam int unsigned DefWInfo = 20;

  typedef enum logic [DefWType-1:0] {
    ErrTagEccSbe  = 4'h1,
    ErrDataEccSbe = 4'h2,
    ErrRsvd       = 4'hf
  } err_type_e;

  typedef struct packed {
    logic                vld;
    logic [DefWType-1:0] typ;
    logic [DefWInfo-1:0] info;
  } err_src_t;

endpackage

// File: rtl/dce_err_src_sel.sv
// Combinational source selector: counts valid sources and picks the lowest-index
// valid source's type/info for capture.
module dce_err_src_sel
  import dce_err_pkg::*;
#(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned W_TYPE = DefWType,
  parameter int unsigned W_INFO = DefWInfo,
  parameter int unsigned W_N    = $clog2(N_SRC + 1)
) (
  input  logic [N_SRC-1:0]        i_err_valid,
  input  logic [N_SRC*W_TYPE-1:0] i_err_type,
  input  logic [N_SRC*W_INFO-1:0] i_err_info,
  output logic [W_N-1:0]          o_n,
  output logic [W_TYPE-1:0]       o_type,
  output logic [W_INFO-1:0]       o_info
);

  // Walk from the top down so the lowest valid index is written last.
  always_comb begin
    o_n    = '0;
    o_type = '0;
    o_info = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_err_valid[i]) begin
        o_n    = o_n + W_N'(1);
        o_type = i_err_type[i*W_TYPE +: W_TYPE];
        o_info = i_err_info[i*W_INFO +: W_INFO];
      end
    end
  end

endmodule

// File: rtl/dce_corr_err_logger.sv
// Correctable-error counter with threshold, valid/overflow status, capture
// registers and the correctable interrupt.
module dce_corr_err_logger
  import dce_err_pkg::*;
#(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned W_COUNT = 8,
  parameter int unsigned W_TYPE  = DefWType,
  parameter int unsigned W_INFO  = DefWInfo
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N_SRC-1:0]        i_err_valid,
  input  logic [N_SRC*W_TYPE-1:0] i_err_type,
  input  logic [N_SRC*W_INFO-1:0] i_err_info,
  input  logic                    i_err_det_en,
  input  logic                    i_err_int_en,
  input  logic [W_COUNT-1:0]      i_err_threshold,
  input  logic                    i_w1c_err_vld,
  input  logic                    i_w1c_err_ovf,
  output logic                    o_err_vld,
  output logic                    o_err_ovf,
  output logic [W_COUNT-1:0]      o_err_count,
  output logic [W_TYPE-1:0]       o_err_type_q,
  output logic [W_INFO-1:0]       o_err_info_q,
  output logic                    o_irq_c
);

  localparam int unsigned W_N   = $clog2(N_SRC + 1);
  localparam int unsigned W_SUM = W_COUNT + 1;

  logic [W_N-1:0]     w_n;
  logic [W_TYPE-1:0]  w_sel_type;
  logic [W_INFO-1:0]  w_sel_info;
  logic               w_event;
  logic [W_SUM-1:0]   w_sum;

  logic               r_vld;
  logic               r_ovf;
  logic [W_COUNT-1:0] r_count;
  logic [W_TYPE-1:0]  r_type;
  logic [W_INFO-1:0]  r_info;

  dce_err_src_sel #(
    .N_SRC  (N_SRC),
    .W_TYPE (W_TYPE),
    .W_INFO (W_INFO),
    .W_N    (W_N)
  ) u_src_sel (
    .i_err_valid (i_err_valid),
    .i_err_type  (i_err_type),
    .i_err_info  (i_err_info),
    .o_n         (w_n),
    .o_type      (w_sel_type),
    .o_info      (w_sel_info)
  );

  assign w_event = i_err_det_en & (|i_err_valid);
  // One extra bit so a sum past the counter width still compares correctly.
  assign w_sum   = {1'b0, r_count} + W_SUM'(w_n);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
      r_count <= '0;
      r_type  <= '0;
      r_info  <= '0;
    end else if (r_vld) begin
      // Logged state is frozen; any new error is overflow, which beats W1C.
      if (w_event) begin
        r_ovf <= 1'b1;
      end else if (i_w1c_err_ovf) begin
        r_ovf <= 1'b0;
      end
      if (i_w1c_err_vld) begin
        r_vld   <= 1'b0;
        r_count <= '0;
      end
    end else begin
      if (i_w1c_err_ovf) begin
        r_ovf <= 1'b0;
      end
      if (w_event) begin
        if (w_sum > {1'b0, i_err_threshold}) begin
          r_vld   <= 1'b1;
          r_count <= i_err_threshold;
          r_type  <= w_sel_type;
          r_info  <= w_sel_info;
        end else begin
          r_count <= w_sum[W_COUNT-1:0];
        end
      end
    end
  end

  assign o_err_vld    = r_vld;
  assign o_err_ovf    = r_ovf;
  assign o_err_count  = r_count;
  assign o_err_type_q = r_type;
  assign o_err_info_q = r_info;
  assign o_irq_c      = i_err_int_en & r_vld;

endmodule

// File: tb/tb_dce_corr_err_logger.sv
// Directed self-checking bench for dce_corr_err_logger with hand-computed expectations.
module tb_dce_corr_err_logger;
  import dce_err_pkg::*;

  localparam int unsigned N_SRC   = 4;
  localparam int unsigned W_COUNT = 8;
  localparam int unsigned W_TYPE  = 4;
  localparam int unsigned W_INFO  = 20;

  logic                    clk;
  logic                    reset;
  logic [N_SRC-1:0]        err_valid;
  logic [N_SRC*W_TYPE-1:0] err_type;
  logic [N_SRC*W_INFO-1:0] err_info;
  logic                    err_det_en;
  logic                    err_int_en;
  logic [W_COUNT-1:0]      err_threshold;
  logic                    w1c_err_vld;
  logic                    w1c_err_ovf;
  logic                    err_vld;
  logic                    err_ovf;
  logic [W_COUNT-1:0]      err_count;
  logic [W_TYPE-1:0]       err_type_q;
  logic [W_INFO-1:0]       err_info_q;
  logic                    irq_c;

  int n_chk;
  int n_pass;

  dce_corr_err_logger #(
    .N_SRC   (N_SRC),
    .W_COUNT (W_COUNT),
    .W_TYPE  (W_TYPE),
    .W_INFO  (W_INFO)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_err_valid     (err_valid),
    .i_err_type      (err_type),
    .i_err_info      (err_info),
    .i_err_det_en    (err_det_en),
    .i_err_int_en    (err_int_en),
    .i_err_threshold (err_threshold),
    .i_w1c_err_vld   (w1c_err_vld),
    .i_w1c_err_ovf   (w1c_err_ovf),
    .o_err_vld       (err_vld),
    .o_err_ovf       (err_ovf),
    .o_err_count     (err_count),
    .o_err_type_q    (err_type_q),
    .o_err_info_q    (err_info_q),
    .o_irq_c         (irq_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Apply current inputs for one cycle, then release the pulse inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    err_valid   = '0;
    w1c_err_vld = 1'b0;
    w1c_err_ovf = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic vld, input logic ovf,
                           input logic [W_COUNT-1:0] cnt);
    check({tag, ".vld"}, 32'(err_vld), 32'(vld));
    check({tag, ".ovf"}, 32'(err_ovf), 32'(ovf));
    check({tag, ".cnt"}, 32'(err_count), 32'(cnt));
  endtask

  task automatic chk_cap(input string tag, input logic [W_TYPE-1:0] t,
                         input logic [W_INFO-1:0] inf);
    check({tag, ".type"}, 32'(err_type_q), 32'(t));
    check({tag, ".info"}, 32'(err_info_q), 32'(inf));
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    // src0: tag/0x11111, src1: data/0x22222, src2: tag/0x33333, src3: data/0x44444
    err_type      = {ErrDataEccSbe, ErrTagEccSbe, ErrDataEccSbe, ErrTagEccSbe};
    err_info      = {20'h44444, 20'h33333, 20'h22222, 20'h11111};
    err_valid     = '0;
    err_det_en    = 1'b0;
    err_int_en    = 1'b0;
    err_threshold = 8'd3;
    w1c_err_vld   = 1'b0;
    w1c_err_ovf   = 1'b0;
    reset         = 1'b1;
    @(posedge clk);
    reset = 1'b1;
    tick();

    chk_state("rst", 1'b0, 1'b0, 8'd0);
    chk_cap("rst", 4'd0, 20'd0);
    check("rst.irq", 32'(irq_c), 32'd0);

    // Threshold 3: three single pulses count up, fourth crosses.
    err_det_en = 1'b1;
    err_int_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      err_valid = 4'b0001;
      tick();
      chk_state($sformatf("cnt%0d", i), 1'b0, 1'b0, 8'(i));
    end
    err_valid = 4'b0001;
    tick();
    chk_state("cross", 1'b1, 1'b0, 8'd3);
    chk_cap("cross", 4'd1, 20'h11111);
    check("cross.irq", 32'(irq_c), 32'd1);
    err_int_en = 1'b0;
    #1;
    check("irq_drop", 32'(irq_c), 32'd0);
    err_int_en = 1'b1;

    // Overflow on src2, capture frozen.
    repeat (2) begin
      err_valid = 4'b0100;
      tick();
    end
    chk_state("ovf", 1'b1, 1'b1, 8'd3);
    chk_cap("ovf", 4'd1, 20'h11111);
    w1c_err_ovf = 1'b1;
    tick();
    chk_state("w1c_ovf", 1'b1, 1'b0, 8'd3);

    // Event alongside w1c_err_vld is charged as overflow.
    err_valid   = 4'b0010;
    w1c_err_vld = 1'b1;
    tick();
    chk_state("w1c_vld_evt", 1'b0, 1'b1, 8'd0);
    chk_cap("w1c_vld_evt", 4'd1, 20'h11111);
    check("w1c_vld_evt.irq", 32'(irq_c), 32'd0);
    w1c_err_ovf = 1'b1;
    tick();
    chk_state("clr_ovf", 1'b0, 1'b0, 8'd0);

    // Detection disabled: pulses ignored.
    err_det_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      err_valid = 4'b1111;
      tick();
    end
    chk_state("det_off", 1'b0, 1'b0, 8'd0);
    err_det_en = 1'b1;

    // Threshold 0 with interrupts off: first error sets vld, irq stays low.
    err_int_en    = 1'b0;
    err_threshold = 8'd0;
    err_valid     = 4'b1000;
    tick();
    chk_state("thr0", 1'b1, 1'b0, 8'd0);
    chk_cap("thr0", 4'd2, 20'h44444);
    check("thr0.irq", 32'(irq_c), 32'd0);
    err_valid = 4'b0001;
    tick();
    chk_state("thr0_ovf", 1'b1, 1'b1, 8'd0);
    check("thr0_ovf.irq", 32'(irq_c), 32'd0);
    w1c_err_vld = 1'b1;
    w1c_err_ovf = 1'b1;
    tick();
    chk_state("clr_both", 1'b0, 1'b0, 8'd0);

    // Threshold 5, multi-source pulses: 2+2=4, then 3 more crosses.
    err_int_en    = 1'b1;
    err_threshold = 8'd5;
    err_valid     = 4'b0011;
    tick();
    err_valid = 4'b0011;
    tick();
    chk_state("multi4", 1'b0, 1'b0, 8'd4);
    err_valid = 4'b1011;
    tick();
    chk_state("multi_cross", 1'b1, 1'b0, 8'd5);
    chk_cap("multi_cross", 4'd1, 20'h11111);
    check("multi_cross.irq", 32'(irq_c), 32'd1);

    // Overflow set wins over same-cycle w1c_err_ovf.
    err_valid   = 4'b0100;
    w1c_err_ovf = 1'b1;
    tick();
    chk_state("set_wins", 1'b1, 1'b1, 8'd5);

    // Threshold lowered below current count: next event crosses.
    w1c_err_vld = 1'b1;
    w1c_err_ovf = 1'b1;
    tick();
    err_valid = 4'b1111;
    tick();
    chk_state("pre_thr_chg", 1'b0, 1'b0, 8'd4);
    err_threshold = 8'd2;
    err_valid     = 4'b0010;
    tick();
    chk_state("thr_chg", 1'b1, 1'b0, 8'd2);
    chk_cap("thr_chg", 4'd2, 20'h22222);
    err_valid = 4'b1000;
    tick();
    chk_state("pre_rst", 1'b1, 1'b1, 8'd2);

    // Mid-run reset, same-cycle event ignored.
    reset     = 1'b1;
    err_valid = 4'b0001;
    tick();
    chk_state("mid_rst", 1'b0, 1'b0, 8'd0);
    chk_cap("mid_rst", 4'd0, 20'd0);
    check("mid_rst.irq", 32'(irq_c), 32'd0);

    // w1c_err_vld while vld=0 has no effect on normal counting.
    err_threshold = 8'd3;
    err_valid     = 4'b0001;
    w1c_err_vld   = 1'b1;
    tick();
    chk_state("w1c_idle", 1'b0, 1'b0, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
